// File: rtl/axi_read_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | axi_read_arbiter_if                                                        |
// | Front-end request/response and AXI AR/R signals of the read arbiter.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface axi_read_arbiter_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [15:0]             req_len;
  logic [5:0]              req_size;
  logic [3:0]              req_burst;
  logic [1:0]              resp_valid;
  logic [1:0]              resp_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_last;
  logic                    resp_err;

  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arlock;
  logic [3:0]              m_axi_arcache;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arready;
  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  // Arbiter side
  modport master (
    input  req_valid, req_addr, req_len, req_size, req_burst, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last, resp_err,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arvalid, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  // Requesters and AXI slave side
  modport slave (
    output req_valid, req_addr, req_len, req_size, req_burst, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last, resp_err,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arvalid, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// +----------------------------------------------------------------------------+
// | axi_read_arbiter                                                           |
// | Round-robin share of one AXI read channel between fetch (0) and load (1).  |
// | Optional beat checker: define ARB_BEAT_CHECK_EN.                           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_read_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  wire logic             clk,
  input  wire logic             reset,
  axi_read_arbiter_if.master    bus,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;

  logic                  w_req_any;
  logic                  w_grant;
  logic [1:0]            w_req_ready;
  logic [1:0]            w_resp_valid;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_resp_last;
  logic                  w_resp_err;
  logic [ID_WIDTH-1:0]   w_arid;

  assign w_req_any = |bus.req_valid;
  // With both requesting, the port that did not win last time goes next.
  assign w_grant   = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
  assign w_arid    = {{(ID_WIDTH-1){1'b0}}, r_grant};

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 2'b00;
    w_resp_valid = 2'b00;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_resp_last  = 1'b0;
    w_resp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_req_ready[w_grant] = 1'b1;
          w_next_state         = S_ADDR;
        end
      end
      S_ADDR: begin
        w_arvalid = 1'b1;
        if (bus.m_axi_arready) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        w_resp_valid[r_grant] = bus.m_axi_rvalid;
        w_rready              = bus.resp_ready[r_grant];
        w_resp_last           = bus.m_axi_rlast;
        w_resp_err            = (bus.m_axi_rresp != 2'b00);
        if (bus.m_axi_rvalid && w_rready && bus.m_axi_rlast) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_req_any) begin
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        r_addr       <= w_grant ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : bus.req_addr[ADDR_WIDTH-1:0];
        r_len        <= w_grant ? bus.req_len[15:8]   : bus.req_len[7:0];
        r_size       <= w_grant ? bus.req_size[5:3]   : bus.req_size[2:0];
        r_burst      <= w_grant ? bus.req_burst[3:2]  : bus.req_burst[1:0];
      end
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.resp_valid    = w_resp_valid;
  assign bus.resp_data     = bus.m_axi_rdata;
  assign bus.resp_last     = w_resp_last;
  assign bus.resp_err      = w_resp_err;
  assign bus.m_axi_arid    = w_arid;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = r_len;
  assign bus.m_axi_arsize  = r_size;
  assign bus.m_axi_arburst = r_burst;
  assign bus.m_axi_arvalid = w_arvalid;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0000;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_rready  = w_rready;

`ifdef ARB_BEAT_CHECK_EN
  logic [7:0] r_beat_cnt;
  logic       r_proto_err;
  logic       w_beat;

  assign w_beat = (r_state == S_DATA) && bus.m_axi_rvalid && w_rready;

  // r_beat_cnt is the zero-based index of the beat being accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt  <= 8'd0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == S_ADDR && bus.m_axi_arready) begin
        r_beat_cnt <= 8'd0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_beat && ((bus.m_axi_rid != w_arid) ||
                     ( bus.m_axi_rlast && r_beat_cnt != r_len) ||
                     (!bus.m_axi_rlast && r_beat_cnt == r_len))) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the core's single AXI read channel (AR + R) between two requesters: port 0 = instruction fetch, port 1 = data load.
- Round-robin grant; the winner owns the bus from AR issue through the R beat carrying rlast.
- At most one burst outstanding.
- Sits between the fetch/load front-ends and the top-level m_axi_ar*/m_axi_r* pins.

Parameters:
ID_WIDTH  13  AXI ID width; arid = granted port index, zero-extended
ADDR_WIDTH  64  address width
DATA_WIDTH  64  read data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-port read request valid
req_ready  out  2  per-port request accepted (one-cycle pulse)
req_addr  in  2*ADDR_WIDTH  per-port address (port 0 in low slice)
req_len  in  2*8  per-port AXI arlen
req_size  in  2*3  per-port AXI arsize
req_burst  in  2*2  per-port AXI arburst
resp_valid  out  2  per-port read beat valid
resp_ready  in  2  per-port beat accept
resp_data  out  DATA_WIDTH  beat data (shared, qualify with resp_valid)
resp_last  out  1  last beat of burst
resp_err  out  1  rresp != 0 on current beat
m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  AXI widths  AR channel
m_axi_arlock/arcache/arprot  out  1/4/3  constant 0
m_axi_arready  in  1  AR ready
m_axi_rid/rdata/rresp/rlast/rvalid  in  AXI widths  R channel
m_axi_rready  out  1  R ready
proto_err  out  1  sticky beat-count error (feature-gated)

Behaviour:
- States: IDLE, ADDR, DATA. Reset -> IDLE, last_grant=1 (so port 0 wins first), all valid/ready outputs 0, captured AR fields 0, proto_err 0.
- IDLE:
  - If exactly one req_valid is set, grant that port.
  - If both are set, grant the port != last_grant.
  - req_ready[g]=1 combinationally in this cycle only. Capture addr/len/size/burst into registers, set grant=g, last_grant<=g, go to ADDR.
  - No req_valid: stay in IDLE.
- ADDR:
  - m_axi_arvalid=1; AR fields driven from registers and held stable.
  - arid=grant.
  - On arready, go to DATA (next cycle arvalid=0). Minimum request-to-AR latency is 1 cycle.
- DATA:
  - R routed combinationally: resp_valid[grant]=m_axi_rvalid, other port 0.
  - m_axi_rready=resp_ready[grant]; resp_data=rdata; resp_last=rlast; resp_err=(rresp!=0).
  - On rvalid&&rready&&rlast, go to IDLE. The next grant can be issued in the cycle after rlast, so back-to-back bursts have a 1-cycle IDLE gap.
- req_ready is never asserted outside IDLE. Requests that arrive mid-burst wait, holding req_valid and fields stable.
- A beat with rid != grant is still delivered. Error flagging for this is the optional feature's job only.
- Port with req_valid dropped before grant: no effect, no grant.
- Reset mid-operation (ADDR or DATA): immediate return to IDLE next cycle; arvalid/rready drop; the in-flight burst is abandoned.
- arlen=0: single beat, rlast on the first beat.
- Error beats (rresp != 0) do not alter sequencing.

Optional Feature:
ARB_BEAT_CHECK_EN
- Defined:
  - An 8-bit beat counter clears on entering DATA and increments per accepted beat.
  - proto_err is set (sticky until reset) if rlast arrives with count != captured len, if count would exceed len without rlast, or if rid != grant on any beat.
- Undefined: no counter; proto_err tied 0.

Test Plan:
- Port 0 only, addr 0x1000, len 7, size 2, burst WRAP, arready immediate -> arvalid 1 cycle after req_valid, arid=0, 8 beats to port 0, resp_last on beat 8, back to IDLE.
- Both ports valid from reset -> port 0 granted first. On completion, port 1 (addr 0x2000, len 0) is granted with arid=1. Next simultaneous request grants port 0.
- arready held low 5 cycles -> arvalid high and araddr/arlen stable for all 6 cycles; no req_ready pulse during the stall.
- resp_ready[1] toggled 1,0,1 over a 4-beat burst -> m_axi_rready mirrors it; no beat lost or duplicated; port 0 resp_valid stays 0.
- Reset asserted on beat 3 of 8 -> next cycle state IDLE, rready=0, arvalid=0; a new port 0 request is granted normally.
- ARB_BEAT_CHECK_EN defined, len 3 burst with rlast on beat 2 -> proto_err rises and stays 1 until reset. With the macro undefined, the same stimulus gives proto_err=0.
